bpsk_mod_st: RTL and testbench



---
 rtl/bpsk_pkg.sv | 25 ++
 rtl/bpsk_negsat.sv | 21 ++
 rtl/bpsk_mod_st.sv | 111 +++++++++++
 tb/tb_bpsk_mod_st.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared types and helpers for the BPSK modulator: FSM state encoding,
// counter width and saturation limits for a signed sample width.
package bpsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int maxpos(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int minneg(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/bpsk_negsat.sv
// Conditional negate of a signed sample; the most negative code maps to the
// most positive code so the result never wraps.
module bpsk_negsat
  import bpsk_pkg::*;
#(
  parameter int mpr = 10
) (
  input  logic signed [mpr-1:0] x_i,
  input  logic                  neg_i,
  output logic signed [mpr-1:0] y_o
);

  localparam logic signed [mpr-1:0] MAXPOS = mpr'(maxpos(mpr));
  localparam logic signed [mpr-1:0] MINNEG = mpr'(minneg(mpr));

  always_comb begin
    y_o = x_i;
    if (neg_i) y_o = (x_i == MINNEG) ? MAXPOS : -x_i;
  end

endmodule

// File: rtl/bpsk_mod_st.sv
// BPSK / DBPSK modulator: holds each (optionally differential) bit for sps
// NCO samples and multiplies the carrier by +/-1, emitting zeros when idle.
module bpsk_mod_st
  import bpsk_pkg::*;
#(
  parameter int mpr     = 10,
  parameter int sps     = 16,
  parameter int diff_en = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic signed [mpr-1:0] fcos_i,
  input  logic                  nco_valid_i,
  input  logic                  bit_i,
  input  logic                  bit_valid_i,
  output logic                  bit_ready_o,
  output logic signed [mpr-1:0] mod_o,
  output logic                  out_valid,
  output logic                  sym_start_o,
  output logic                  busy_o,
  output logic                  underrun_o
);

  localparam int CW = clog2(sps);
  localparam logic [CW-1:0] LAST = CW'(sps - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sym_q, sym_d;
  logic                  dprev_q, dprev_d;
  logic                  underrun_q, underrun_d;
  logic                  start_q, start_d;
  logic                  valid_q, valid_d;
  logic signed [mpr-1:0] mod_q, mod_d;
  logic signed [mpr-1:0] carrier;
  logic                  tick, at_last, accept, d_bit;

  bpsk_negsat #(.mpr(mpr)) u_negsat (
    .x_i   (fcos_i),
    .neg_i (sym_d),
    .y_o   (carrier)
  );

  always_comb begin
    tick        = clken & nco_valid_i;
    at_last     = (cnt_q == LAST);
    bit_ready_o = tick & ((state_q == IDLE) | at_last);
    accept      = bit_ready_o & bit_valid_i;
    d_bit       = (diff_en != 0) ? (bit_i ^ dprev_q) : bit_i;

    state_d    = state_q;
    cnt_d      = cnt_q;
    sym_d      = sym_q;
    dprev_d    = dprev_q;
    underrun_d = underrun_q;
    mod_d      = mod_q;
    start_d    = 1'b0;
    valid_d    = tick;

    if (tick) begin
      // A newly accepted symbol modulates the very sample that accepted it.
      if (accept) begin
        state_d = RUN;
        cnt_d   = '0;
        sym_d   = d_bit;
        dprev_d = d_bit;
        start_d = 1'b1;
      end else if (state_q == RUN) begin
        if (!at_last) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          state_d    = IDLE;
          cnt_d      = '0;
          dprev_d    = 1'b0;
          underrun_d = 1'b1;
        end
      end
      mod_d = (state_d == RUN) ? carrier : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sym_q      <= 1'b0;
      dprev_q    <= 1'b0;
      underrun_q <= 1'b0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      mod_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sym_q      <= sym_d;
      dprev_q    <= dprev_d;
      underrun_q <= underrun_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
      mod_q      <= mod_d;
    end
  end

  assign mod_o       = mod_q;
  assign out_valid   = valid_q;
  assign sym_start_o = start_q;
  assign busy_o      = (state_q == RUN);
  assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_bpsk_mod_st.sv
// Scoreboard bench: plain (dut0) and differential (dut1) modulators share
// stimulus; a symbol-level model queues expected samples for a monitor.
module tb_bpsk_mod_st;

  localparam int MPR = 10;
  localparam int SPS = 4;

  typedef struct packed {
    logic                  v;
    logic signed [MPR-1:0] mod;
    logic                  st;
    logic                  busy;
    logic                  ur;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  clken = 1'b0;
  logic                  nco_valid = 1'b0;
  logic                  bit_in = 1'b0;
  logic                  bit_valid = 1'b0;
  logic signed [MPR-1:0] fcos = '0;
  logic [1:0]            ready, ov, ss, busy, ur;
  logic signed [MPR-1:0] mod [2];

  int  tests = 0;
  int  fails = 0;
  bit  started = 1'b0;

  exp_t q0[$];
  exp_t q1[$];

  bit                    m_run   [2];
  int                    m_left  [2];
  bit                    m_sym   [2];
  bit                    m_dprev [2];
  bit                    m_ur    [2];
  logic signed [MPR-1:0] m_mod   [2];

  always #5 clk = ~clk;

  bpsk_mod_st #(.mpr(MPR), .sps(SPS), .diff_en(0)) dut0 (
    .clk(clk), .reset(reset), .clken(clken), .fcos_i(fcos),
    .nco_valid_i(nco_valid), .bit_i(bit_in), .bit_valid_i(bit_valid),
    .bit_ready_o(ready[0]), .mod_o(mod[0]), .out_valid(ov[0]),
    .sym_start_o(ss[0]), .busy_o(busy[0]), .underrun_o(ur[0])
  );

  bpsk_mod_st #(.mpr(MPR), .sps(SPS), .diff_en(1)) dut1 (
    .clk(clk), .reset(reset), .clken(clken), .fcos_i(fcos),
    .nco_valid_i(nco_valid), .bit_i(bit_in), .bit_valid_i(bit_valid),
    .bit_ready_o(ready[1]), .mod_o(mod[1]), .out_valid(ov[1]),
    .sym_start_o(ss[1]), .busy_o(busy[1]), .underrun_o(ur[1])
  );

  function automatic int carr(input int c, input bit s);
    if (!s) return c;
    if (c == -(1 << (MPR - 1))) return (1 << (MPR - 1)) - 1;
    return -c;
  endfunction

  task automatic model_step(input int k, input bit r, input bit ce, input bit nv,
                            input bit b, input bit bv, input int c);
    exp_t e;
    bit   tick, rdy, d;
    tick = ce & nv;
    rdy  = tick & (!m_run[k] || m_left[k] == 0);
    tests++;
    if (ready[k] !== rdy) begin
      fails++;
      $display("FAIL bit_ready dut%0d t=%0t got=%b exp=%b", k, $time, ready[k], rdy);
    end
    e = '0;
    if (r) begin
      m_run[k] = 0; m_left[k] = 0; m_sym[k] = 0; m_dprev[k] = 0; m_ur[k] = 0;
      m_mod[k] = '0;
    end else if (tick) begin
      e.v = 1'b1;
      if (rdy && bv) begin
        d = (k == 1) ? (b ^ m_dprev[k]) : b;
        m_dprev[k] = d; m_sym[k] = d; m_run[k] = 1; m_left[k] = SPS - 1;
        e.st = 1'b1;
        m_mod[k] = MPR'(carr(c, d));
      end else if (m_run[k] && m_left[k] > 0) begin
        m_left[k]--;
        m_mod[k] = MPR'(carr(c, m_sym[k]));
      end else if (m_run[k]) begin
        m_run[k] = 0; m_dprev[k] = 0; m_ur[k] = 1;
        m_mod[k] = '0;
      end else begin
        m_mod[k] = '0;
      end
    end
    e.mod  = m_mod[k];
    e.busy = m_run[k];
    e.ur   = m_ur[k];
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit ce, input bit nv, input bit b,
                     input bit bv, input int c);
    @(negedge clk);
    reset = r; clken = ce; nco_valid = nv; bit_in = b; bit_valid = bv;
    fcos = MPR'(c);
    #1;
    for (int k = 0; k < 2; k++) model_step(k, r, ce, nv, b, bv, c);
    started = 1'b1;
  endtask

  // One symbol: offer the bit at the boundary, then fill with optional gaps.
  task automatic sym_seq(input bit b, input int c, input bit stall);
    cyc(0, 1, 1, b, 1, c);
    for (int i = 1; i < SPS; i++) begin
      if (stall) cyc(0, 1, 0, b, 1, c);
      cyc(0, 1, 1, b, 0, c);
    end
  endtask

  task automatic chk(input int k, input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t got=%0d exp=%0d", nm, k, $time, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    wait (started);
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          tests++; fails++;
          $display("FAIL scoreboard_empty dut%0d t=%0t got=empty exp=entry", k, $time);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk(k, "out_valid", int'(ov[k]), int'(e.v));
          chk(k, "busy", int'(busy[k]), int'(e.busy));
          chk(k, "underrun", int'(ur[k]), int'(e.ur));
          if (e.v) begin
            chk(k, "mod", int'(mod[k]), int'(e.mod));
            chk(k, "sym_start", int'(ss[k]), int'(e.st));
          end
        end
      end
    end
  end

  initial begin : driver
    int rc;
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_left[k] = 0; m_sym[k] = 0; m_dprev[k] = 0; m_ur[k] = 0;
      m_mod[k] = '0;
    end
    repeat (2) cyc(1, 1, 1, 0, 0, 100);
    sym_seq(0, 100, 0); sym_seq(1, 100, 0);
    repeat (4) cyc(0, 1, 1, 0, 0, 100);

    cyc(1, 1, 1, 0, 0, 50);
    sym_seq(1, 50, 0); sym_seq(1, 50, 0); sym_seq(0, 50, 0); sym_seq(1, 50, 0);
    repeat (2) cyc(0, 1, 1, 0, 0, 50);

    cyc(1, 1, 1, 0, 0, 0);
    sym_seq(1, -512, 0); sym_seq(1, 511, 0); sym_seq(0, 511, 0); sym_seq(1, -512, 0);
    sym_seq(0, 77, 1); sym_seq(1, 77, 1);
    cyc(0, 0, 1, 1, 1, 77); cyc(0, 1, 1, 1, 1, 77);

    cyc(1, 1, 1, 0, 0, 50);
    cyc(0, 1, 1, 1, 1, 50); cyc(0, 1, 1, 1, 0, 50); cyc(0, 1, 1, 1, 0, 50);
    cyc(1, 1, 1, 1, 0, 50);
    sym_seq(1, 50, 0);

    sym_seq(1, 60, 0);
    repeat (4) cyc(0, 1, 1, 0, 0, 60);
    sym_seq(1, 60, 0); sym_seq(0, 60, 0);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(7))
        0:       rc = -512;
        1:       rc = 511;
        default: rc = int'($urandom_range(1023)) - 512;
      endcase
      cyc($urandom_range(99) == 0, $urandom_range(9) != 0, $urandom_range(3) != 0,
          $urandom_range(1) == 1, $urandom_range(7) != 0, rc);
    end
    cyc(0, 1, 1, 0, 0, 0);
    @(negedge clk);
    #5;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
